// File: rtl/gb_bus_pkg.sv
// Shared types and widths for the Game Boy CPU-side bus initiator.
package gb_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Bus sequencer states: IDLE separates transactions, SETUP presents the
    // address (and write data) with strobes high, STROBE is the single
    // active-low select cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    // One queued bus request.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/gb_bus_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags and no bypass:
// an entry written at edge T is first visible (empty=0) after that edge.
module gb_bus_req_fifo
    import gb_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    output logic full,
    input  logic pop,
    output req_t pop_data,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    // A push is refused while the registered full flag is set, even if a pop
    // happens in the same cycle; ready reopens on the following cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy after this edge, used to derive the registered flags.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and flags; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
        end
    end

    // Storage array; contents need no reset because the flags gate all reads.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/gb_bus_initiator.sv
// Game Boy CPU-side bus master: queues requests and issues each one as
// IDLE -> SETUP (xSETUP_CYCLES) -> STROBE on a fully registered bus.
module gb_bus_initiator
    import gb_bus_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    // Request handshake: a request transfers on every rising edge where
    // req_valid && req_ready; req_ready depends only on registered state, and
    // a requester holding req_valid keeps its fields stable until it transfers.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              nread,
    output logic              nwrite,
    output logic              nsel,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    // Last SETUP count value; unused when SETUP_CYCLES is 0.
    localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [2:0]        setup_cnt;
    logic [2:0]        setup_cnt_next;
    req_t              op_q;
    req_t              op_next;

    req_t              fifo_wr;
    req_t              fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic [ADDR_W-1:0] addr_next;
    logic              nsel_next;
    logic              nread_next;
    logic              nwrite_next;
    logic              oe_next;
    logic [DATA_W-1:0] dout_next;
    logic              oe_q;
    logic [DATA_W-1:0] dout_q;

    // Read requests store zero data so their req_wdata never reaches the bus.
    assign fifo_wr = '{write: req_write,
                       addr:  req_addr,
                       wdata: req_write ? req_wdata : '0};

    gb_bus_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_valid),
        .push_data (fifo_wr),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .empty     (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // Data bus is only driven from the registered output enable.
    assign data_bus = oe_q ? dout_q : {DATA_W{1'bz}};

    // Next-state logic, then next bus values decoded from the state being
    // entered so every bus pin comes straight from a flop.
    always_comb begin
        state_next     = state;
        setup_cnt_next = setup_cnt;
        op_next        = op_q;
        fifo_pop       = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    op_next        = fifo_rd;
                    setup_cnt_next = '0;
                    state_next     = (SETUP_CYCLES > 0) ? SETUP : STROBE;
                end
            end
            SETUP: begin
                if (setup_cnt == SETUP_LAST) begin
                    state_next = STROBE;
                end else begin
                    setup_cnt_next = setup_cnt + 1'b1;
                end
            end
            STROBE: begin
                // Always return to IDLE: guarantees an all-high cycle and
                // a released data bus between transactions.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        addr_next   = address_bus;
        nsel_next   = 1'b1;
        nread_next  = 1'b1;
        nwrite_next = 1'b1;
        oe_next     = 1'b0;
        dout_next   = dout_q;

        case (state_next)
            SETUP: begin
                addr_next = op_next.addr;
                oe_next   = op_next.write;
                dout_next = op_next.wdata;
            end
            STROBE: begin
                addr_next   = op_next.addr;
                nsel_next   = 1'b0;
                nread_next  = op_next.write;
                nwrite_next = !op_next.write;
                oe_next     = op_next.write;
                dout_next   = op_next.wdata;
            end
            default: begin
                // IDLE keeps the last address and releases everything else.
            end
        endcase
    end

    // State, latched request, registered bus pins, response and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            setup_cnt   <= '0;
            op_q        <= '0;
            address_bus <= '0;
            nsel        <= 1'b1;
            nread       <= 1'b1;
            nwrite      <= 1'b1;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            state       <= state_next;
            setup_cnt   <= setup_cnt_next;
            op_q        <= op_next;
            address_bus <= addr_next;
            nsel        <= nsel_next;
            nread       <= nread_next;
            nwrite      <= nwrite_next;
            oe_q        <= oe_next;
            dout_q      <= dout_next;

            // Read data is sampled at the edge that ends the STROBE cycle.
            rsp_valid <= (state == STROBE) && !op_q.write;
            if ((state == STROBE) && !op_q.write) begin
                rsp_rdata <= data_bus;
            end

            if (state == STROBE) begin
                if (op_q.write) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
        end
    end

endmodule
